game_controller: RTL
====================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter: TICK_DIV, 500000, clock cycles per base tick (>=1).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: btn_run  input  1  debounced level; rising edge toggles run/pause.
REQ-005 SHALL have port: btn_step  input  1  debounced level; rising edge requests one generation while paused.
REQ-006 SHALL have port: btn_clear  input  1  debounced level; rising edge requests board clear.
REQ-007 SHALL have port: btn_speed  input  1  debounced level; rising edge advances speed.
REQ-008 SHALL have port: gen_start  output  1  one-cycle pulse: life engine computes next generation.
REQ-009 SHALL have port: gen_done  input  1  one-cycle pulse from engine: generation complete.
REQ-010 SHALL have port: clear_start  output  1  one-cycle pulse: engine clears board.
REQ-011 SHALL have port: clear_done  input  1  one-cycle pulse from engine: clear complete.
REQ-012 SHALL have port: running  output  1  run mode flag.
REQ-013 SHALL have port: speed  output  2  current speed index.
REQ-014 SHALL have port: gen_count  output  16  generations completed since last clear.

Function
REQ-015 SHALL register each button once (btn_*_q); edge = btn & ~btn_q; FSM acts on edge in same cycle; all outputs registered.
REQ-016 SHALL implement FSM states IDLE (paused), WAIT (running, counting), GEN (awaiting gen_done), CLEAR (awaiting clear_done).
REQ-017 SHALL use wait length = TICK_DIV << (3 - speed) cycles: speed 0 slowest (8 ticks), speed 3 fastest (1 tick).
REQ-018 SHALL, on run edge in IDLE: set running=1, load wait counter, enter WAIT; first gen_start after one full wait length.
REQ-019 SHALL, on run edge in WAIT: clear running, enter IDLE, discard counter; no gen_start.
REQ-020 SHALL, on WAIT counter expiry: pulse gen_start for exactly one cycle, enter GEN.
REQ-021 SHALL, on step edge in IDLE: pulse gen_start in the cycle after btn_step first sampled high, enter GEN; step edges in WAIT, GEN, CLEAR ignored.
REQ-022 SHALL, on run edge in GEN: toggle running only; state stays GEN.
REQ-023 SHALL, on gen_done in GEN (including first GEN cycle): increment gen_count (wrap 0xFFFF -> 0x0000); go to WAIT with counter reloaded if running, else IDLE.
REQ-024 SHALL ignore gen_done outside GEN and clear_done outside CLEAR.
REQ-025 SHALL, on clear edge in IDLE or WAIT: clear running, pulse clear_start one cycle, enter CLEAR.
REQ-026 SHALL, on clear edge in GEN: set clear_pending, clear running; on gen_done, count it, then pulse clear_start next cycle and enter CLEAR.
REQ-027 SHALL, in CLEAR: ignore run and step edges; on clear_done set gen_count=0, clear clear_pending, enter IDLE.
REQ-028 SHALL prioritise simultaneous edges: clear > run > step.
REQ-029 SHALL advance speed on each speed edge in any state (3 wraps to 0); new value applies at next counter load only.
REQ-030 SHALL never assert gen_start and clear_start in the same cycle, nor either for more than one cycle.

Reset
REQ-031 SHALL, while rst_n low, force: state IDLE, running=0, speed=0, gen_count=0, gen_start=0, clear_start=0, clear_pending=0, counter=0, all btn_*_q=1.
REQ-032 SHALL NOT produce an edge on the first cycle after reset for a button already held high.
REQ-033 SHALL abandon any in-progress GEN/CLEAR on mid-operation reset; no completion pulse is remembered.

Verification (TICK_DIV=4)
REQ-034 Step: idle, btn_step rises -> gen_start high 1 cycle next cycle; gen_done 3 cycles later -> gen_count=1, state IDLE.
REQ-035 Run at speed 3: btn_run rises, engine returns gen_done after 2 cycles -> gen_start pulses every 4+1+2 cycles; gen_count counts 1,2,3.
REQ-036 Speed: four btn_speed edges -> speed 1,2,3,0; speed 0 running -> gen_start interval 32 cycles from WAIT entry.
REQ-037 Clear during GEN: btn_clear rises while awaiting gen_done -> no clear_start until gen_done; then clear_start next cycle; clear_done -> gen_count=0, running=0, IDLE.
REQ-038 Simultaneous: btn_clear and btn_run rise same cycle in IDLE -> clear_start only, running stays 0; gen_count at 0xFFFF + gen_done -> 0x0000.
REQ-039 Reset: rst_n low mid-GEN with btn_run held -> all outputs reset immediately; after release no run edge, state IDLE.

Source files
------------

// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_controller
// Purpose  : run/pause/step/clear sequencing and tick pacing for a life engine
// Revision : 1.0
// ============================================================================
module game_controller #(
  parameter int TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_clear,
  input  logic        btn_speed,
  output logic        gen_start,
  input  logic        gen_done,
  output logic        clear_start,
  input  logic        clear_done,
  output logic        running,
  output logic [1:0]  speed,
  output logic [15:0] gen_count
);

  localparam int CNT_W = $clog2(TICK_DIV) + 4;
  localparam logic [CNT_W-1:0] c_TICK_DIV = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_GEN   = 2'd2;
  localparam logic [1:0] c_CLEAR = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic             r_btnRunQ, r_btnStepQ, r_btnClearQ, r_btnSpeedQ;
  logic             r_clearPending;
  logic [CNT_W-1:0] r_count;

  logic             w_runEdge, w_stepEdge, w_clearEdge, w_speedEdge;
  logic             w_genRunning;
  logic [CNT_W-1:0] w_loadVal;

  logic             w_genStartNxt, w_clearStartNxt, w_runningNxt, w_pendingNxt;
  logic [15:0]      w_genCountNxt;
  logic [CNT_W-1:0] w_countNxt;

  assign w_runEdge   = btn_run   & ~r_btnRunQ;
  assign w_stepEdge  = btn_step  & ~r_btnStepQ;
  assign w_clearEdge = btn_clear & ~r_btnClearQ;
  assign w_speedEdge = btn_speed & ~r_btnSpeedQ;

  // Counter holds remaining WAIT cycles minus one; expiry is the cycle it reads zero.
  assign w_loadVal = (c_TICK_DIV << (2'd3 - speed)) - c_ONE;

  // While a clear is pending the run button is locked out; running stays low.
  assign w_genRunning = w_clearEdge ? 1'b0 : (running ^ (w_runEdge & ~r_clearPending));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_clearEdge)     w_nextState = c_CLEAR;
        else if (w_runEdge)  w_nextState = c_WAIT;
        else if (w_stepEdge) w_nextState = c_GEN;
      end
      c_WAIT: begin
        if (w_clearEdge)        w_nextState = c_CLEAR;
        else if (w_runEdge)     w_nextState = c_IDLE;
        else if (r_count == '0) w_nextState = c_GEN;
      end
      c_GEN: begin
        if (gen_done) begin
          if (w_clearEdge || r_clearPending) w_nextState = c_CLEAR;
          else if (w_genRunning)             w_nextState = c_WAIT;
          else                               w_nextState = c_IDLE;
        end
      end
      default: begin
        if (clear_done) w_nextState = c_IDLE;
      end
    endcase
  end

  always_comb begin
    w_genStartNxt   = (r_state != c_GEN)   && (w_nextState == c_GEN);
    w_clearStartNxt = (r_state != c_CLEAR) && (w_nextState == c_CLEAR);
    w_runningNxt    = running;
    w_pendingNxt    = r_clearPending;
    w_genCountNxt   = gen_count;
    case (r_state)
      c_IDLE:  w_runningNxt = (w_nextState == c_WAIT);
      c_WAIT:  w_runningNxt = (w_nextState == c_WAIT) || (w_nextState == c_GEN);
      c_GEN: begin
        w_runningNxt = w_genRunning;
        if (w_clearEdge) w_pendingNxt = 1'b1;
        if (gen_done)    w_genCountNxt = gen_count + 16'd1;
      end
      default: begin
        w_runningNxt = 1'b0;
        if (clear_done) begin
          w_genCountNxt = 16'd0;
          w_pendingNxt  = 1'b0;
        end
      end
    endcase
    if (w_nextState == c_WAIT && r_state != c_WAIT) begin
      w_countNxt = w_loadVal;
    end else if (w_nextState == c_WAIT) begin
      w_countNxt = r_count - c_ONE;
    end else begin
      w_countNxt = '0;
    end
  end

  // Button history resets high so a button held through reset gives no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btnRunQ      <= 1'b1;
      r_btnStepQ     <= 1'b1;
      r_btnClearQ    <= 1'b1;
      r_btnSpeedQ    <= 1'b1;
      gen_start      <= 1'b0;
      clear_start    <= 1'b0;
      running        <= 1'b0;
      speed          <= 2'd0;
      gen_count      <= 16'd0;
      r_clearPending <= 1'b0;
      r_count        <= '0;
    end else begin
      r_btnRunQ      <= btn_run;
      r_btnStepQ     <= btn_step;
      r_btnClearQ    <= btn_clear;
      r_btnSpeedQ    <= btn_speed;
      gen_start      <= w_genStartNxt;
      clear_start    <= w_clearStartNxt;
      running        <= w_runningNxt;
      speed          <= speed + {1'b0, w_speedEdge};
      gen_count      <= w_genCountNxt;
      r_clearPending <= w_pendingNxt;
      r_count        <= w_countNxt;
    end
  end

endmodule
`default_nettype wire
